// File: rtl/timer_counter.sv
// Programmable down-counting timer with CTRL/PRESET/COUNT registers and a maskable IRQ.
// Define TIMER_IRQ_STICKY_EN to make the interrupt flag sticky until software writes CTRL.
module timer_counter #(
  parameter logic [31:0] RST_PRESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        We,
  input  logic [31:0] DIn,
  output logic [31:0] DOut,
  output logic        IRQ
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] CNT  = 2'd2;
  localparam logic [1:0] INT  = 2'd3;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        flag;

  logic        en;
  logic [1:0]  mode;
  logic        im;
  logic        auto_reload;
  logic        ctrl_we;
  logic        preset_we;
  logic        count_zero;

  always_comb begin
    en          = ctrl[0];
    mode        = ctrl[2:1];
    im          = ctrl[3];
    auto_reload = (mode == 2'b01);
    ctrl_we     = We && (Addr == ADDR_CTRL);
    preset_we   = We && (Addr == ADDR_PRESET);
    count_zero  = (count == '0);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (en) state_nxt = LOAD;
      LOAD: state_nxt = CNT;
      CNT: begin
        if (!en)            state_nxt = IDLE;
        else if (count_zero) state_nxt = INT;
      end
      INT: state_nxt = auto_reload ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // PRESET is only sampled in LOAD, so mid-count PRESET writes wait for the next reload.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (state == LOAD) begin
      count <= preset;
    end else if ((state == CNT) && en && !count_zero) begin
      count <= count - 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         preset <= RST_PRESET;
    else if (preset_we) preset <= DIn;
  end

  // A software CTRL write overrides the one-shot En clear in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl <= '0;
    end else if (ctrl_we) begin
      ctrl <= DIn[3:0];
    end else if ((state == INT) && !auto_reload) begin
      ctrl[0] <= 1'b0;
    end
  end

`ifdef TIMER_IRQ_STICKY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flag <= 1'b0;
    end else if ((state == CNT) && (state_nxt == INT)) begin
      flag <= 1'b1;
    end else if (ctrl_we) begin
      flag <= 1'b0;
    end
  end
`else
  always_comb begin
    flag = (state == INT);
  end
`endif

  always_comb begin
    IRQ = flag & im;
  end

  always_comb begin
    DOut = '0;
    case (Addr)
      ADDR_CTRL:   DOut = {28'd0, ctrl};
      ADDR_PRESET: DOut = preset;
      ADDR_COUNT:  DOut = count;
      default:     DOut = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: a phase/age model checked every cycle plus literal expectations.
module tb_timer_counter;

  localparam logic [31:0] RSTP = 32'h0000_00A5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  Addr = 2'd0;
  logic        We = 1'b0;
  logic [31:0] DIn = '0;
  logic [31:0] DOut;
  logic        IRQ;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  timer_counter #(.RST_PRESET(RSTP)) dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .We   (We),
    .DIn  (DIn),
    .DOut (DOut),
    .IRQ  (IRQ)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: a running timer is described by its age in cycles since entering LOAD.
  // age 0 = LOAD, 1..lp+1 = counting (COUNT = lp-(age-1)), lp+2 = expiry cycle.
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  logic [31:0] m_lp;
  bit          m_active;
  int          m_age;
  bit          m_flag;
  logic [3:0]  m_nc;
  bit          m_expire;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ctrl = '0; m_preset = RSTP; m_count = '0; m_lp = '0;
      m_active = 0; m_age = 0; m_flag = 0;
    end else begin
      m_nc = m_ctrl;
      m_expire = 0;
      if (!m_active) begin
        if (m_ctrl[0]) begin m_active = 1; m_age = 0; end
      end else if (m_age == 0) begin
        m_lp = m_preset; m_count = m_preset; m_age = 1;
      end else if (m_age <= int'(m_lp) + 1) begin
        if (!m_ctrl[0]) m_active = 0;
        else begin
          m_age++;
          if (m_age <= int'(m_lp) + 1) m_count = m_lp - 32'(m_age - 1);
          else m_expire = 1;
        end
      end else begin
        if (m_ctrl[2:1] == 2'b01) m_age = 0;
        else begin m_active = 0; m_nc[0] = 1'b0; end
      end
      if (We && Addr == 2'd0) m_nc = DIn[3:0];
      if (We && Addr == 2'd1) m_preset = DIn;
      if (m_expire) m_flag = 1;
      else if (We && Addr == 2'd0) m_flag = 0;
      m_ctrl = m_nc;
    end
  end

  function automatic logic exp_irq();
    bit f;
`ifdef TIMER_IRQ_STICKY_EN
    f = m_flag;
`else
    f = m_active && (m_age == int'(m_lp) + 2);
`endif
    return f & m_ctrl[3];
  endfunction

  function automatic logic [31:0] exp_dout(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return '0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      check("model_dout", DOut, exp_dout(Addr));
      check("model_irq", {31'd0, IRQ}, {31'd0, exp_irq()});
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Addr = a; DIn = d; We = 1'b1;
    @(posedge clk); #1;
    We = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
    Addr = a; #1;
    check(name, DOut, exp);
  endtask

  initial begin
    int n;
    // Reset state while held and after release
    repeat (2) @(negedge clk);
    rd("rst_ctrl", 2'd0, 32'd0);
    rd("rst_preset", 2'd1, RSTP);
    rd("rst_count", 2'd2, 32'd0);
    check("rst_irq", {31'd0, IRQ}, 32'd0);
    @(negedge clk); #1 reset = 1'b1;
    tick(1);
    rd("rel_preset", 2'd1, RSTP);
    check("rel_irq", {31'd0, IRQ}, 32'd0);

    // Writes to COUNT/reserved are ignored; CTRL keeps only 4 bits
    wr(2'd2, 32'hDEAD_BEEF);
    wr(2'd3, 32'h1234_5678);
    rd("ign_count", 2'd2, 32'd0);
    rd("ign_rsvd", 2'd3, 32'd0);
    rd("ign_preset", 2'd1, RSTP);
    wr(2'd0, 32'hFFFF_FFF0);
    rd("ctrl_upper", 2'd0, 32'd0);

    // One-shot, PRESET=5: IRQ 8 edges after the CTRL write
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    Addr = 2'd2;
    for (int k = 1; k <= 9; k++) begin
      tick(1);
      if (k == 7) check("os5_irq_e7", {31'd0, IRQ}, 32'd0);
      if (k == 8) check("os5_irq_e8", {31'd0, IRQ}, 32'd1);
`ifndef TIMER_IRQ_STICKY_EN
      if (k == 9) check("os5_irq_e9", {31'd0, IRQ}, 32'd0);
`endif
    end
    rd("os5_ctrl", 2'd0, 32'h8);
    rd("os5_count", 2'd2, 32'd0);
    wr(2'd0, 32'd0);
    tick(2);

    // PRESET=0: IRQ 3 edges after the write, one-cycle pulse
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      if (k == 2) check("p0_irq_e2", {31'd0, IRQ}, 32'd0);
      if (k == 3) check("p0_irq_e3", {31'd0, IRQ}, 32'd1);
`ifndef TIMER_IRQ_STICKY_EN
      if (k == 4) check("p0_irq_e4", {31'd0, IRQ}, 32'd0);
`endif
    end
    wr(2'd0, 32'd0);
    tick(3);

    // Auto-reload, PRESET=2: period 5, COUNT 2,1,0
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);
    Addr = 2'd2;
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      if (k == 2) check("ar_cnt_2", DOut, 32'd2);
      if (k == 3) check("ar_cnt_1", DOut, 32'd1);
      if (k == 4) check("ar_cnt_0", DOut, 32'd0);
      if (k == 5 || k == 10 || k == 15) check("ar_irq_hi", {31'd0, IRQ}, 32'd1);
`ifndef TIMER_IRQ_STICKY_EN
      if (k == 4 || k == 9 || k == 14) check("ar_irq_lo", {31'd0, IRQ}, 32'd0);
`endif
      if (k == 8) check("ar_cnt_k8", DOut, 32'd1);
    end
    wr(2'd0, 32'd0);
    tick(6);

    // Stop mid-count at 4, then restart from PRESET
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    Addr = 2'd2;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (DOut == 32'd5) break;
      n++;
    end
    check("stop_poll", {31'd0, n < 40}, 32'd1);
    #1;
    wr(2'd0, 32'd0);
    rd("stop_cnt_a", 2'd2, 32'd4);
    tick(5);
    check("stop_cnt_b", DOut, 32'd4);
    check("stop_irq", {31'd0, IRQ}, 32'd0);
    wr(2'd0, 32'h1);
    rd("re_cnt_a", 2'd2, 32'd4);
    tick(1);
    check("re_cnt_b", DOut, 32'd4);
    tick(1);
    check("re_cnt_load", DOut, 32'd10);
    wr(2'd0, 32'd0);
    tick(4);

    // CTRL write in the INT cycle beats the one-shot En clear
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h1);
    tick(3);
    wr(2'd0, 32'h9);
    rd("prio_ctrl", 2'd0, 32'h9);
    tick(3);
    check("prio_irq", {31'd0, IRQ}, 32'd1);
    tick(1);
    rd("prio_ctrl_end", 2'd0, 32'h8);
    wr(2'd0, 32'd0);
    tick(2);

    // Asynchronous reset mid-count aborts without IRQ
    wr(2'd1, 32'd6);
    wr(2'd0, 32'h9);
    tick(4);
    reset = 1'b0;
    rd("ar_rst_count", 2'd2, 32'd0);
    rd("ar_rst_ctrl", 2'd0, 32'd0);
    rd("ar_rst_preset", 2'd1, RSTP);
    check("ar_rst_irq", {31'd0, IRQ}, 32'd0);
    @(negedge clk); #1 reset = 1'b1;
    tick(15);
    check("ar_rst_irq_late", {31'd0, IRQ}, 32'd0);

`ifdef TIMER_IRQ_STICKY_EN
    // Sticky flag: masked expiry, cleared by CTRL write; unmasked stays until write
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h1);
    tick(8);
    check("st_masked", {31'd0, IRQ}, 32'd0);
    wr(2'd0, 32'h8);
    check("st_cleared", {31'd0, IRQ}, 32'd0);
    wr(2'd0, 32'h9);
    tick(6);
    check("st_set", {31'd0, IRQ}, 32'd1);
    tick(4);
    check("st_held", {31'd0, IRQ}, 32'd1);
    wr(2'd0, 32'h8);
    check("st_wclear", {31'd0, IRQ}, 32'd0);
    tick(2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
